osecpu_seg7_display: RTL and testbench

//   Downstream consumer of the OSECPU core status outputs (dr, cr, pc); drives the 4-digit multiplexed 7-segment display.

---
 rtl/osecpu_seg7_display_pkg.sv | 21 ++
 rtl/osecpu_seg7_display_hex_to_seg7.sv | 28 ++
 rtl/osecpu_seg7_display.sv | 104 ++++++++++
 tb/tb_osecpu_seg7_display.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/osecpu_seg7_display_pkg.sv
// Shared constants for the OSECPU 7-segment status display.
// Supplies the halt bit index when the codebase-wide def.v has not already defined it.
`ifndef BIT_CR_HLT
`define BIT_CR_HLT 0
`endif
`ifndef SEG7_OFF
`define SEG7_OFF 8'hFF
`endif
`ifndef SEG7_DIGITS
`define SEG7_DIGITS 4
`endif

package osecpu_seg7_display_pkg;
    localparam logic [7:0] SEG7_BLANK = `SEG7_OFF;
    localparam int         SEG7_NDIG  = `SEG7_DIGITS;

    // Active-low one-hot digit enable for a slot index.
    function automatic logic [3:0] digit_sel_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction
endpackage

// File: rtl/osecpu_seg7_display_hex_to_seg7.sv
// Hex nibble to 7-segment font {g,f,e,d,c,b,a}, active-high.
module hex_to_seg7 (
    input  logic [3:0] nib_i,
    output logic [6:0] font_o
);
    always_comb begin
        font_o = 7'h00;
        unique case (nib_i)
            4'h0: font_o = 7'h3F;
            4'h1: font_o = 7'h06;
            4'h2: font_o = 7'h5B;
            4'h3: font_o = 7'h4F;
            4'h4: font_o = 7'h66;
            4'h5: font_o = 7'h6D;
            4'h6: font_o = 7'h7D;
            4'h7: font_o = 7'h07;
            4'h8: font_o = 7'h7F;
            4'h9: font_o = 7'h6F;
            4'hA: font_o = 7'h77;
            4'hB: font_o = 7'h7C;
            4'hC: font_o = 7'h39;
            4'hD: font_o = 7'h5E;
            4'hE: font_o = 7'h79;
            4'hF: font_o = 7'h71;
            default: font_o = 7'h00;
        endcase
    end
endmodule

// File: rtl/osecpu_seg7_display.sv
// 4-digit multiplexed display of OSECPU pc while running, paged dr snapshot once halted.
// Optional SEG7_LZB_EN blanks leading zero digits of the shown 16-bit word.
module osecpu_seg7_display
    import osecpu_seg7_display_pkg::*;
#(
    parameter int REFRESH_DIV = 6250,
    parameter int PAGE_FRAMES = 250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] dr,
    input  logic [7:0]  cr,
    input  logic [15:0] pc,
    output logic [7:0]  seg,
    output logic [3:0]  segsel,
    output logic        latched
);
    localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int FRM_W = (PAGE_FRAMES > 1) ? $clog2(PAGE_FRAMES) : 1;

    logic [DIV_W-1:0] div_q;
    logic [1:0]       idx_q;
    logic             page_q, page_d;
    logic [FRM_W-1:0] frm_q, frm_d;
    logic [31:0]      snap_q;
    logic             latched_q;
    logic [7:0]       seg_q, seg_d;
    logic [3:0]       segsel_q;

    logic        wrap, capture, dp, blank;
    logic [15:0] word;
    logic [3:0]  nib;
    logic [6:0]  font;
    logic        unused_cr;

    assign unused_cr = ^cr;
    assign wrap      = (div_q == DIV_W'(REFRESH_DIV - 1));
    assign capture   = cr[`BIT_CR_HLT] && !latched_q;

    // idx_q is the slot loaded at the next wrap, so idx_q==0 on a wrap is the 3->0 frame boundary.
    always_comb begin
        page_d = page_q;
        frm_d  = frm_q;
        if (latched_q && wrap && idx_q == 2'd0) begin
            if (frm_q == FRM_W'(PAGE_FRAMES - 1)) begin
                frm_d  = '0;
                page_d = ~page_q;
            end else begin
                frm_d = frm_q + 1'b1;
            end
        end
    end

    // page_d so the first digit of a new page already shows the new half.
    assign word = latched_q ? (page_d ? snap_q[31:16] : snap_q[15:0]) : pc;
    assign nib  = word[{idx_q, 2'b00} +: 4];
    assign dp   = (idx_q == 2'd3) && latched_q && page_d;

    hex_to_seg7 u_font (
        .nib_i  (nib),
        .font_o (font)
    );

`ifdef SEG7_LZB_EN
    assign blank = (idx_q != 2'd0) && ((word >> {idx_q, 2'b00}) == 16'h0000);
`else
    assign blank = 1'b0;
`endif

    assign seg_d = blank ? {~dp, 7'h7F} : ~{dp, font};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q     <= '0;
            idx_q     <= '0;
            page_q    <= 1'b0;
            frm_q     <= '0;
            snap_q    <= '0;
            latched_q <= 1'b0;
            seg_q     <= SEG7_BLANK;
            segsel_q  <= 4'hF;
        end else begin
            div_q <= wrap ? '0 : div_q + 1'b1;
            if (wrap) begin
                idx_q    <= idx_q + 2'd1;
                seg_q    <= seg_d;
                segsel_q <= digit_sel_n(idx_q);
            end
            if (capture) begin
                snap_q    <= dr;
                latched_q <= 1'b1;
                page_q    <= 1'b0;
                frm_q     <= '0;
            end else begin
                page_q <= page_d;
                frm_q  <= frm_d;
            end
        end
    end

    assign seg     = seg_q;
    assign segsel  = segsel_q;
    assign latched = latched_q;
endmodule

// File: tb/tb_osecpu_seg7_display.sv
// Directed bench for osecpu_seg7_display with a slot/frame-level reference model.
`ifndef BIT_CR_HLT
`define BIT_CR_HLT 0
`endif
module tb_osecpu_seg7_display;
    localparam int R = 4;
    localparam int P = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] dr = '0;
    logic [7:0]  cr = '0;
    logic [15:0] pc = 16'h1234;
    logic [7:0]  seg;
    logic [3:0]  segsel;
    logic        latched;

    int n_cmp = 0;
    int n_err = 0;

    osecpu_seg7_display #(.REFRESH_DIV(R), .PAGE_FRAMES(P)) dut (
        .clk     (clk),
        .reset   (reset),
        .dr      (dr),
        .cr      (cr),
        .pc      (pc),
        .seg     (seg),
        .segsel  (segsel),
        .latched (latched)
    );

    always #5 clk = ~clk;

    logic [6:0] font_tbl [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [7:0] exp_seg(input logic [15:0] w, input int d, input bit upper);
        logic [15:0] sh;
        logic        dp;
        sh = w >> (4 * d);
        dp = (d == 3) && upper;
`ifdef SEG7_LZB_EN
        if (d > 0 && sh == 16'h0000) return dp ? 8'h7F : 8'hFF;
`endif
        return ~{dp, font_tbl[sh[3:0]]};
    endfunction

    // Model: edges since release; slot k loads at edge k*R showing digit (k-1)%4.
    int          e = 0;
    bit          cap = 1'b0;
    int          nfr = 0;
    logic [31:0] m_snap = '0;
    logic [7:0]  m_seg = 8'hFF;
    logic [3:0]  m_sel = 4'hF;
    logic        m_lat = 1'b0;

    always @(posedge clk or negedge reset) begin
        int  d;
        bit  up;
        if (!reset) begin
            e = 0; cap = 1'b0; nfr = 0;
            m_seg = 8'hFF; m_sel = 4'hF; m_lat = 1'b0;
        end else begin
            e++;
            if (e % R == 0) begin
                d = ((e / R) - 1) % 4;
                if (cap && d == 0) nfr++;
                up = cap && ((nfr / P) % 2 == 1);
                m_sel = ~(4'b0001 << d);
                m_seg = exp_seg(cap ? (up ? m_snap[31:16] : m_snap[15:0]) : pc, d, up);
            end
            if (!cap && cr[`BIT_CR_HLT]) begin
                cap = 1'b1; m_snap = dr; m_lat = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        n_cmp++;
        if ({seg, segsel, latched} !== {m_seg, m_sel, m_lat}) begin
            n_err++;
            $display("FAIL model t=%0t seg/segsel/latched got %h/%h/%b want %h/%h/%b",
                     $time, seg, segsel, latched, m_seg, m_sel, m_lat);
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    // Waits for segsel to leave s, then to reach s (bounded).
    task automatic wait_sel(input logic [3:0] s);
        int n = 0;
        while (segsel == s && n < 100) begin @(posedge clk); #1; n++; end
        while (segsel != s && n < 100) begin @(posedge clk); #1; n++; end
        if (n >= 100) begin
            n_cmp++; n_err++;
            $display("FAIL wait_sel timeout got %h want %h", segsel, s);
        end
    endtask

    task automatic slot_chk(input string name, input logic [3:0] s, input logic [7:0] exp);
        wait_sel(s);
        chk(name, seg, exp);
    endtask

    logic [7:0] zero_seg;

    initial begin
`ifdef SEG7_LZB_EN
        zero_seg = 8'hFF;
`else
        zero_seg = 8'hC0;
`endif
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seg", seg, 8'hFF);
        chk("rst_sel", {4'h0, segsel}, 8'h0F);
        chk("rst_lat", {7'h0, latched}, 8'h00);

        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("first_wait_sel", {4'h0, segsel}, 8'h0F);
        @(posedge clk);
        #1 chk("first_sel", {4'h0, segsel}, 8'h0E);
        chk("pc_d0", seg, 8'h99);

        slot_chk("pc_d1", 4'hD, 8'hB0);
        slot_chk("pc_d2", 4'hB, 8'hA4);
        slot_chk("pc_d3", 4'h7, 8'hF9);
        slot_chk("pc_d0b", 4'hE, 8'h99);

        @(negedge clk);
        dr = 32'hFFFF_FFFC;
        cr = 8'h01 << `BIT_CR_HLT;
        @(negedge clk);
        cr = 8'h00;
        chk("latched", {7'h0, latched}, 8'h01);
        dr = 32'h0;
        pc = 16'h0000;

        slot_chk("lo_d0", 4'hE, 8'hC6);
        slot_chk("lo_d1", 4'hD, 8'h8E);
        slot_chk("lo_d2", 4'hB, 8'h8E);
        slot_chk("lo_d3", 4'h7, 8'h8E);
        slot_chk("up_d0", 4'hE, 8'h8E);
        slot_chk("up_d1", 4'hD, 8'h8E);
        slot_chk("up_d2", 4'hB, 8'h8E);
        slot_chk("up_d3_dp", 4'h7, 8'h0E);
        slot_chk("up2_d0", 4'hE, 8'h8E);
        slot_chk("up2_d1", 4'hD, 8'h8E);
        slot_chk("up2_d2", 4'hB, 8'h8E);
        chk("still_latched", {7'h0, latched}, 8'h01);

        @(negedge clk) reset = 1'b0;
        #1;
        chk("midrst_seg", seg, 8'hFF);
        chk("midrst_sel", {4'h0, segsel}, 8'h0F);
        chk("midrst_lat", {7'h0, latched}, 8'h00);
        pc = 16'h0007;
        repeat (2) @(negedge clk);
        reset = 1'b1;

        slot_chk("p7_d0", 4'hE, 8'hF8);
        slot_chk("p7_d1", 4'hD, zero_seg);
        slot_chk("p7_d2", 4'hB, zero_seg);
        slot_chk("p7_d3", 4'h7, zero_seg);
        chk("p7_lat", {7'h0, latched}, 8'h00);

        repeat (4) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
